// File: rtl/pool_flatten.sv
// Drains pooled feature maps from the banked BUF2 and serializes them channel-major
// as a valid/ready word stream, buffering returned reads in a 2-entry output queue.
module pool_flatten #(
    parameter int N_BUF     = 8,
    parameter int LOG_N_BUF = 3,
    parameter int ADDR_RAM  = 12,
    parameter int DATA_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [15:0]               channels,
    input  logic [15:0]               out_size,
    input  logic [ADDR_RAM-1:0]       base_addr,
    output logic [N_BUF-1:0]          rd_en,
    output logic [N_BUF*ADDR_RAM-1:0] rd_addr,
    input  logic [N_BUF*DATA_W-1:0]   rd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [15:0]          idx_reg;
    logic [LOG_N_BUF-1:0] lane_reg;
    logic [15:0]          cb_reg;
    logic [ADDR_RAM-1:0]  blk_off_reg;

    logic                 inflight_reg;
    logic [LOG_N_BUF-1:0] lane_d_reg;
    logic                 last_d_reg;

    logic [1:0]           count_reg;
    logic [DATA_W-1:0]    q_data_reg [2];
    logic                 q_last_reg [2];

    logic                 pop;
    logic                 issue;
    logic                 idx_wrap;
    logic                 lane_wrap;
    logic                 is_last;
    logic [2:0]           occ_sum;
    logic [31:0]          c_cur;
    logic [31:0]          c_final;
    logic [ADDR_RAM-1:0]  addr_cur;
    logic [DATA_W-1:0]    bank_word [N_BUF];
    logic [DATA_W-1:0]    push_data;

    assign pop       = (count_reg != 2'd0) && out_ready;
    assign occ_sum   = {1'b0, count_reg} + {2'b00, inflight_reg};
    // Reserve a queue slot for every outstanding read so the queue can never overflow.
    assign issue     = (state_reg == S_RUN) && (occ_sum < (3'd2 + {2'b00, pop}));

    assign idx_wrap  = (idx_reg == (out_size - 16'd1));
    assign lane_wrap = (lane_reg == LOG_N_BUF'(N_BUF - 1));
    assign c_cur     = ({16'd0, cb_reg} << LOG_N_BUF) + {{(32-LOG_N_BUF){1'b0}}, lane_reg};
    assign c_final   = {16'd0, channels} - 32'd1;
    assign is_last   = idx_wrap && (c_cur == c_final);

    // Modular sum at ADDR_RAM bits equals the wide sum truncated to ADDR_RAM bits.
    assign addr_cur  = base_addr + blk_off_reg + ADDR_RAM'(idx_reg);

    for (genvar gi = 0; gi < N_BUF; gi++) begin : g_bank
        assign rd_en[gi]                          = issue && (lane_reg == LOG_N_BUF'(gi));
        assign rd_addr[gi*ADDR_RAM +: ADDR_RAM]   = rd_en[gi] ? addr_cur : '0;
        assign bank_word[gi]                      = rd_data[gi*DATA_W +: DATA_W];
    end

    assign push_data = bank_word[lane_d_reg];

    assign out_valid = (count_reg != 2'd0);
    assign out_data  = q_data_reg[0];
    assign out_last  = q_last_reg[0] && out_valid;
    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_DONE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (channels == 16'd0 || out_size == 16'd0) state_next = S_DONE;
                    else                                        state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (issue && is_last) state_next = S_FLUSH;
            end
            S_FLUSH: begin
                // Leave as the final word is accepted so done follows it directly.
                if (!inflight_reg && (count_reg == 2'd0 || (count_reg == 2'd1 && pop)))
                    state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            idx_reg       <= '0;
            lane_reg      <= '0;
            cb_reg        <= '0;
            blk_off_reg   <= '0;
            inflight_reg  <= 1'b0;
            lane_d_reg    <= '0;
            last_d_reg    <= 1'b0;
            count_reg     <= 2'd0;
            q_data_reg[0] <= '0;
            q_data_reg[1] <= '0;
            q_last_reg[0] <= 1'b0;
            q_last_reg[1] <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (state_reg == S_IDLE && start) begin
                idx_reg     <= '0;
                lane_reg    <= '0;
                cb_reg      <= '0;
                blk_off_reg <= '0;
            end else if (issue) begin
                if (idx_wrap) begin
                    idx_reg <= '0;
                    if (lane_wrap) begin
                        lane_reg    <= '0;
                        cb_reg      <= cb_reg + 16'd1;
                        blk_off_reg <= blk_off_reg + ADDR_RAM'(out_size);
                    end else begin
                        lane_reg <= lane_reg + LOG_N_BUF'(1);
                    end
                end else begin
                    idx_reg <= idx_reg + 16'd1;
                end
            end

            inflight_reg <= issue;
            last_d_reg   <= issue && is_last;
            if (issue) lane_d_reg <= lane_reg;

            // Entry 0 is the head; it only changes when the head is accepted or the queue is empty.
            case ({inflight_reg, pop})
                2'b10: begin
                    if (count_reg == 2'd0) begin
                        q_data_reg[0] <= push_data;
                        q_last_reg[0] <= last_d_reg;
                    end else begin
                        q_data_reg[1] <= push_data;
                        q_last_reg[1] <= last_d_reg;
                    end
                    count_reg <= count_reg + 2'd1;
                end
                2'b01: begin
                    q_data_reg[0] <= q_data_reg[1];
                    q_last_reg[0] <= q_last_reg[1];
                    count_reg     <= count_reg - 2'd1;
                end
                2'b11: begin
                    if (count_reg == 2'd1) begin
                        q_data_reg[0] <= push_data;
                        q_last_reg[0] <= last_d_reg;
                    end else begin
                        q_data_reg[0] <= q_data_reg[1];
                        q_last_reg[0] <= q_last_reg[1];
                        q_data_reg[1] <= push_data;
                        q_last_reg[1] <= last_d_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
